// File: rtl/cr_huf_comp_st_lut_buf.sv
// Buffers the small-table code-length words from the builder and streams them to the header assembler.
// Optional error checking is enabled by defining ST_LUT_BUF_ERR_CHK_EN.
module cr_huf_comp_st_lut_buf #(
  parameter int HDR_WIDTH = 64,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int SIZE_W    = 8,
  parameter int HCLEN_W   = 4,
  localparam int BITS_W   = $clog2(HDR_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 st_lut_wr,
  input  logic [HDR_WIDTH-1:0] st_lut_wr_data,
  input  logic [ADDR_W-1:0]    st_lut_wr_addr,
  input  logic                 st_lut_wr_done,
  input  logic [SIZE_W-1:0]    st_lut_stcl_size,
  input  logic [HCLEN_W-1:0]   st_lut_hclen,
  output logic                 st_read_done,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [HDR_WIDTH-1:0] rd_data,
  output logic                 rd_last,
  output logic [BITS_W-1:0]    rd_bits,
  output logic [HCLEN_W-1:0]   rd_hclen,
  output logic                 err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] HDR_W32 = HDR_WIDTH;
  localparam logic [31:0] DEPTH32 = DEPTH;

  typedef enum logic [1:0] {IDLE, FILL, READ, DONE} state_t;

  state_t                 state;
  logic [HDR_WIDTH-1:0]   mem [DEPTH];
  logic [CNT_W-1:0]       wcnt;
  logic [IDX_W-1:0]       rdptr;
  logic [SIZE_W-1:0]      size_q;

  logic                   in_fill;
  logic                   addr_ok;
  logic                   wr_ok;
  logic [IDX_W-1:0]       wr_idx;
  logic [CNT_W-1:0]       cnt_next;
  logic                   at_last;
  logic [31:0]            rem;
  logic [BITS_W-1:0]      bits_last;

  // Write acceptance, running word count and last-word bit count.
  always_comb begin
    in_fill   = (state == IDLE) || (state == FILL);
    addr_ok   = 32'(st_lut_wr_addr) < DEPTH32;
    wr_ok     = st_lut_wr && in_fill && addr_ok && !clear;
    wr_idx    = IDX_W'(st_lut_wr_addr);
    cnt_next  = wcnt;
    if (wr_ok && (32'(st_lut_wr_addr) + 32'd1 > 32'(wcnt)))
      cnt_next = CNT_W'(32'(st_lut_wr_addr) + 32'd1);
    at_last   = (32'(rdptr) + 32'd1) == 32'(wcnt);
    rem       = 32'(size_q) - (32'(wcnt) - 32'd1) * HDR_W32;
    bits_last = ((rem == 32'd0) || (rem > HDR_W32)) ? BITS_W'(HDR_WIDTH) : BITS_W'(rem);
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_idx] <= st_lut_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state        <= IDLE;
      wcnt         <= '0;
      rdptr        <= '0;
      size_q       <= '0;
      rd_hclen     <= '0;
      rd_valid     <= 1'b0;
      st_read_done <= 1'b0;
    end else begin
      case (state)
        IDLE, FILL: begin
          wcnt <= cnt_next;
          if (st_lut_wr_done) begin
            size_q   <= st_lut_stcl_size;
            rd_hclen <= st_lut_hclen;
            rdptr    <= '0;
            // An empty table skips streaming entirely.
            if (cnt_next == '0) begin
              state        <= DONE;
              st_read_done <= 1'b1;
            end else begin
              state    <= READ;
              rd_valid <= 1'b1;
            end
          end else if (wr_ok) begin
            state <= FILL;
          end
        end
        READ: begin
          if (rd_valid && rd_ready) begin
            if (at_last) begin
              state        <= DONE;
              rd_valid     <= 1'b0;
              st_read_done <= 1'b1;
            end else begin
              rdptr <= rdptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data = rd_valid ? mem[rdptr] : '0;
  assign rd_last = rd_valid && at_last;
  assign rd_bits = !rd_valid ? '0 : (at_last ? bits_last : BITS_W'(HDR_WIDTH));

`ifdef ST_LUT_BUF_ERR_CHK_EN
  logic err_q;

  // Sticky flag for protocol violations by the builder.
  always_ff @(posedge clk) begin
    if (!rst_n || clear)
      err_q <= 1'b0;
    else if ((st_lut_wr && (!addr_ok || !in_fill)) || (st_lut_wr_done && !in_fill))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cr_huf_comp_st_lut_buf.sv
// Directed self-checking bench for cr_huf_comp_st_lut_buf (HDR_WIDTH 64, DEPTH 4).
module tb_cr_huf_comp_st_lut_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        st_lut_wr = 1'b0;
  logic [63:0] st_lut_wr_data = '0;
  logic [1:0]  st_lut_wr_addr = '0;
  logic        st_lut_wr_done = 1'b0;
  logic [7:0]  st_lut_stcl_size = '0;
  logic [3:0]  st_lut_hclen = '0;
  logic        st_read_done;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [63:0] rd_data;
  logic        rd_last;
  logic [6:0]  rd_bits;
  logic [3:0]  rd_hclen;
  logic        err;

  int checks = 0;
  int errors = 0;

  cr_huf_comp_st_lut_buf dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .st_lut_wr(st_lut_wr), .st_lut_wr_data(st_lut_wr_data), .st_lut_wr_addr(st_lut_wr_addr),
    .st_lut_wr_done(st_lut_wr_done), .st_lut_stcl_size(st_lut_stcl_size), .st_lut_hclen(st_lut_hclen),
    .st_read_done(st_read_done), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .rd_bits(rd_bits), .rd_hclen(rd_hclen), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are observed one falling edge later.
  task automatic step();
    @(negedge clk);
    st_lut_wr      = 1'b0;
    st_lut_wr_done = 1'b0;
    clear          = 1'b0;
  endtask

  task automatic put(input logic [1:0] a, input logic [63:0] d, input logic done,
                     input logic [7:0] size, input logic [3:0] hclen);
    st_lut_wr        = 1'b1;
    st_lut_wr_addr   = a;
    st_lut_wr_data   = d;
    st_lut_wr_done   = done;
    st_lut_stcl_size = size;
    st_lut_hclen     = hclen;
    step();
  endtask

  task automatic do_clear();
    rd_ready = 1'b0;
    clear = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", rd_valid); end
    checks++; if (st_read_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", st_read_done); end
    checks++; if ({rd_data, rd_last, rd_bits, rd_hclen, err} !== '0) begin errors++; $display("[TB] FAIL reset_outs got %h exp 0", {rd_data, rd_last, rd_bits, rd_hclen, err}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    put(2'd0, 64'hA0A0_0000_0000_00A0, 1'b0, 8'd0, 4'd0);
    put(2'd1, 64'hA1A1_0000_0000_00A1, 1'b1, 8'd100, 4'd5);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %b exp 1", rd_valid); end
    checks++; if (rd_data !== 64'hA0A0_0000_0000_00A0) begin errors++; $display("[TB] FAIL basic_data0 got %h exp a0a0...a0", rd_data); end
    checks++; if ({rd_last, rd_bits} !== {1'b0, 7'd64}) begin errors++; $display("[TB] FAIL basic_beat0 last/bits got %b/%0d exp 0/64", rd_last, rd_bits); end
    checks++; if (rd_hclen !== 4'd5) begin errors++; $display("[TB] FAIL basic_hclen got %0d exp 5", rd_hclen); end
    rd_ready = 1'b1;
    step();
    checks++; if (rd_data !== 64'hA1A1_0000_0000_00A1) begin errors++; $display("[TB] FAIL basic_data1 got %h exp a1a1...a1", rd_data); end
    checks++; if ({rd_valid, rd_last, rd_bits} !== {1'b1, 1'b1, 7'd36}) begin errors++; $display("[TB] FAIL basic_beat1 v/last/bits got %b/%b/%0d exp 1/1/36", rd_valid, rd_last, rd_bits); end
    step();
    checks++; if ({rd_valid, st_read_done} !== 2'b01) begin errors++; $display("[TB] FAIL basic_done valid/done got %b exp 01", {rd_valid, st_read_done}); end
    checks++; if (rd_hclen !== 4'd5) begin errors++; $display("[TB] FAIL basic_hclen_hold got %0d exp 5", rd_hclen); end
    do_clear();
    checks++; if ({st_read_done, rd_hclen} !== 5'd0) begin errors++; $display("[TB] FAIL basic_clear got %b exp 0", {st_read_done, rd_hclen}); end
  endtask

  task automatic test_exact_multiple();
    put(2'd0, 64'h1111, 1'b0, 8'd0, 4'd0);
    put(2'd1, 64'h2222, 1'b1, 8'd128, 4'd9);
    rd_ready = 1'b1;
    step();
    checks++; if ({rd_last, rd_bits} !== {1'b1, 7'd64}) begin errors++; $display("[TB] FAIL exact_last last/bits got %b/%0d exp 1/64", rd_last, rd_bits); end
    step();
    checks++; if ({rd_valid, st_read_done} !== 2'b01) begin errors++; $display("[TB] FAIL exact_no_extra valid/done got %b exp 01", {rd_valid, st_read_done}); end
    do_clear();
  endtask

  task automatic test_stall();
    logic [63:0] exp_data [4];
    logic        exp_valid [4];
    logic [0:3]  ready_seq;
    ready_seq = 4'b1001;
    exp_data  = '{64'hB1, 64'hB1, 64'hB1, 64'h0};
    exp_valid = '{1'b1, 1'b1, 1'b1, 1'b0};
    put(2'd0, 64'hB0, 1'b0, 8'd0, 4'd0);
    put(2'd1, 64'hB1, 1'b1, 8'd128, 4'd2);
    checks++; if (rd_data !== 64'hB0) begin errors++; $display("[TB] FAIL stall_first got %h exp b0", rd_data); end
    for (int i = 0; i < 4; i++) begin
      rd_ready = ready_seq[i];
      step();
      checks++; if ({rd_valid, rd_data} !== {exp_valid[i], exp_data[i]}) begin errors++; $display("[TB] FAIL stall_cycle%0d valid/data got %b/%h exp %b/%h", i, rd_valid, rd_data, exp_valid[i], exp_data[i]); end
    end
    checks++; if (st_read_done !== 1'b1) begin errors++; $display("[TB] FAIL stall_done got %b exp 1", st_read_done); end
    do_clear();
  endtask

  task automatic test_empty();
    rd_ready = 1'b1;
    st_lut_wr_done = 1'b1;
    st_lut_stcl_size = 8'd0;
    st_lut_hclen = 4'd3;
    step();
    checks++; if ({rd_valid, st_read_done} !== 2'b01) begin errors++; $display("[TB] FAIL empty_done valid/done got %b exp 01", {rd_valid, st_read_done}); end
    checks++; if (rd_hclen !== 4'd3) begin errors++; $display("[TB] FAIL empty_hclen got %0d exp 3", rd_hclen); end
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_novalid got %b exp 0", rd_valid); end
    do_clear();
  endtask

  task automatic test_clear_mid_read();
    put(2'd0, 64'hC0, 1'b0, 8'd0, 4'd0);
    put(2'd1, 64'hC1, 1'b1, 8'd120, 4'd4);
    rd_ready = 1'b1;
    step();
    do_clear();
    checks++; if ({rd_valid, st_read_done} !== 2'b00) begin errors++; $display("[TB] FAIL clear_idle valid/done got %b exp 00", {rd_valid, st_read_done}); end
    put(2'd0, 64'hD0, 1'b1, 8'd40, 4'd7);
    checks++; if ({rd_valid, rd_data} !== {1'b1, 64'hD0}) begin errors++; $display("[TB] FAIL clear_new valid/data got %b/%h exp 1/d0", rd_valid, rd_data); end
    checks++; if ({rd_last, rd_bits} !== {1'b1, 7'd40}) begin errors++; $display("[TB] FAIL clear_new_bits last/bits got %b/%0d exp 1/40", rd_last, rd_bits); end
    rd_ready = 1'b1;
    step();
    checks++; if ({rd_valid, st_read_done} !== 2'b01) begin errors++; $display("[TB] FAIL clear_new_done valid/done got %b exp 01", {rd_valid, st_read_done}); end
    do_clear();
  endtask

  task automatic test_out_of_order_sat();
    put(2'd2, 64'hE2, 1'b0, 8'd0, 4'd0);
    put(2'd0, 64'hE0, 1'b0, 8'd0, 4'd0);
    put(2'd1, 64'hE1, 1'b1, 8'd10, 4'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({rd_valid, rd_data, rd_last} !== {1'b1, 64'hE0 + 64'(i), i == 2}) begin errors++; $display("[TB] FAIL order_beat%0d valid/data/last got %b/%h/%b", i, rd_valid, rd_data, rd_last); end
      if (i == 2) begin
        checks++; if (rd_bits !== 7'd64) begin errors++; $display("[TB] FAIL order_sat_bits got %0d exp 64", rd_bits); end
      end
      step();
    end
    checks++; if (st_read_done !== 1'b1) begin errors++; $display("[TB] FAIL order_done got %b exp 1", st_read_done); end
    do_clear();
  endtask

  task automatic test_ignored_write();
    put(2'd0, 64'hF0, 1'b1, 8'd64, 4'd6);
    put(2'd0, 64'hBAD, 1'b0, 8'd0, 4'd0);
    checks++; if ({rd_valid, rd_data} !== {1'b1, 64'hF0}) begin errors++; $display("[TB] FAIL ignore_data valid/data got %b/%h exp 1/f0", rd_valid, rd_data); end
`ifdef ST_LUT_BUF_ERR_CHK_EN
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL ignore_err got %b exp 1", err); end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL ignore_err_sticky got %b exp 1", err); end
`else
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL ignore_err_tied got %b exp 0", err); end
`endif
    do_clear();
    checks++; if ({err, rd_valid} !== 2'b00) begin errors++; $display("[TB] FAIL ignore_clear err/valid got %b exp 00", {err, rd_valid}); end
  endtask

  task automatic test_reset_mid_fill();
    put(2'd1, 64'h77, 1'b0, 8'd0, 4'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if ({rd_valid, st_read_done, rd_data, rd_last, rd_bits, rd_hclen, err} !== '0) begin errors++; $display("[TB] FAIL rst_fill_outs nonzero"); end
    st_lut_wr_done = 1'b1;
    st_lut_hclen = 4'd8;
    step();
    checks++; if ({rd_valid, st_read_done} !== 2'b01) begin errors++; $display("[TB] FAIL rst_fill_count valid/done got %b exp 01", {rd_valid, st_read_done}); end
    do_clear();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exact_multiple();
    test_stall();
    test_empty();
    test_clear_mid_read();
    test_out_of_order_sat();
    test_ignored_write();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
